joystick_adc_sequencer: RTL and testbench

- Schedules the single XADC DRP read port across four joystick samples: left X, left Y, right X and right Y.
- Drives the external analog-mux select (joy_s) and the DRP channel address for each sample.
- Waits a programmable settle time after each mux/channel change, issues one DRP read, and captures the result.
- Publishes all four 12-bit samples atomically once per frame, with a one-cycle valid pulse, to the camera-control logic (pitch/yaw update and position scaling).

---
 rtl/joystick_adc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_joystick_adc_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_adc_sequencer.sv
// -----------------------------------------------------------------------------
// joystick_adc_sequencer
//
// Time-shares the single XADC DRP read port across four joystick samples
// (left X, left Y, right X, right Y). For each sample it drives the external
// analog-mux select and the DRP channel address, waits a settle time, issues
// one DRP read and captures the 12-bit result into a shadow register. After
// the fourth sample, all four results are published together with a
// one-cycle frame_valid pulse, so the consumer never sees a mixed frame.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       start/continue frames (looked at only in IDLE and DONE)
//   drp_daddr    DRP address (CH_X_ADDR / CH_Y_ADDR)
//   drp_den      one-cycle DRP read strobe
//   drp_drdy     DRP data ready (looked at only while waiting for a read)
//   drp_do       DRP read data, sample = drp_do[15:4]
//   joy_s        analog mux select, 0 = left stick, 1 = right stick
//   left_x/left_y/right_x/right_y  last published 12-bit samples
//   frame_valid  high for the one cycle in which the samples update
//   busy         high whenever a frame is in progress
//   timeout_err  sticky drdy-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module joystick_adc_sequencer #(
    parameter int         SETTLE_CYCLES  = 1024,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] CH_X_ADDR      = 8'h13,
    parameter logic [7:0] CH_Y_ADDR      = 8'h1B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [7:0]  drp_daddr,
    output logic        drp_den,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    output logic        joy_s,
    output logic [11:0] left_x,
    output logic [11:0] left_y,
    output logic [11:0] right_x,
    output logic [11:0] right_y,
    output logic        frame_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    r_state;
    logic [1:0]    r_slot;
    logic [SW-1:0] r_scnt;
    logic [TW-1:0] r_tcnt;
    logic [11:0]   r_shadow [4];
    logic [11:0]   r_out    [4];
    logic [7:0]    r_daddr;
    logic          r_joy_s;
    logic          r_den;
    logic          r_fv;
    logic          r_terr;

    logic [11:0]   w_sample;
    logic [1:0]    w_next_slot;
    logic          w_unused_do_lsb;

    assign w_sample        = drp_do[15:4];
    assign w_next_slot     = r_slot + 2'd1;
    // The XADC result is left-justified; the low nibble carries no data.
    assign w_unused_do_lsb = &{1'b0, drp_do[3:0]};

    // Slot bit 1 picks the stick (mux), slot bit 0 picks the axis (channel).
    function automatic logic slot_mux(input logic [1:0] slot);
        return slot[1];
    endfunction

    function automatic logic [7:0] slot_addr(input logic [1:0] slot);
        return slot[0] ? CH_Y_ADDR : CH_X_ADDR;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_slot  <= 2'd0;
            r_scnt  <= '0;
            r_tcnt  <= '0;
            r_daddr <= CH_X_ADDR;
            r_joy_s <= 1'b0;
            r_den   <= 1'b0;
            r_fv    <= 1'b0;
            r_terr  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            // Strobes default low; they are raised on the transition into
            // the state they belong to so they line up with that state.
            r_den <= 1'b0;
            r_fv  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_slot  <= 2'd0;
                        r_joy_s <= slot_mux(2'd0);
                        r_daddr <= slot_addr(2'd0);
                        r_scnt  <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_scnt == SETTLE_LAST) begin
                        r_den   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_scnt <= r_scnt + SW'(1);
                    end
                end
                S_REQ: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (drp_drdy) begin
                        r_shadow[r_slot] <= w_sample;
                        if (r_slot == 2'd3) begin
                            // Publish on entry to DONE so the outputs and
                            // frame_valid are both visible during DONE; the
                            // last sample bypasses its shadow register.
                            r_out[0] <= r_shadow[0];
                            r_out[1] <= r_shadow[1];
                            r_out[2] <= r_shadow[2];
                            r_out[3] <= w_sample;
                            r_fv     <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_slot  <= w_next_slot;
                            r_joy_s <= slot_mux(w_next_slot);
                            r_daddr <= slot_addr(w_next_slot);
                            r_scnt  <= '0;
                            r_state <= S_SETTLE;
                        end
                    end else if (r_tcnt == TIMEOUT_LAST) begin
                        // Mux and channel are already settled: re-issue
                        // the read directly without another settle period.
                        r_terr  <= 1'b1;
                        r_den   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_DONE: begin
                    if (enable) begin
                        r_slot  <= 2'd0;
                        r_joy_s <= slot_mux(2'd0);
                        r_daddr <= slot_addr(2'd0);
                        r_scnt  <= '0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign drp_daddr   = r_daddr;
    assign drp_den     = r_den;
    assign joy_s       = r_joy_s;
    assign left_x      = r_out[0];
    assign left_y      = r_out[1];
    assign right_x     = r_out[2];
    assign right_y     = r_out[3];
    assign frame_valid = r_fv;
    assign busy        = (r_state != S_IDLE);
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_joystick_adc_sequencer.sv
module tb_joystick_adc_sequencer;

    localparam int S = 4;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  drp_daddr;
    logic        drp_den;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic        joy_s;
    logic [11:0] left_x, left_y, right_x, right_y;
    logic        frame_valid, busy, timeout_err;

    always #5 clk = ~clk;

    joystick_adc_sequencer #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .CH_X_ADDR     (8'h13),
        .CH_Y_ADDR     (8'h1B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .drp_daddr  (drp_daddr),
        .drp_den    (drp_den),
        .drp_drdy   (drp_drdy),
        .drp_do     (drp_do),
        .joy_s      (joy_s),
        .left_x     (left_x),
        .left_y     (left_y),
        .right_x    (right_x),
        .right_y    (right_y),
        .frame_valid(frame_valid),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // XADC model state
    int          lat        = 1;
    int          cd         = 0;
    bit          in_req     = 0;
    int          req_slot   = 0;
    logic [8:0]  req_val;
    bit          withhold_s1 = 0;
    bit          stray_en   = 0;
    int          stray_cnt  = 0;
    int          since_drdy = 100;
    int          exp_slot   = 0;
    int          resp_frame = 0;
    logic [15:0] dat [8][4];

    // observations
    int          den_cnt = 0, seq_viol = 0, stab_viol = 0, hold_viol = 0;
    int          fv_cnt = 0;
    int          fv_cyc_q[$];
    int          s1_den_cyc[$];
    int          to_rise_cyc = -1;
    int          first_den_slot = -1;
    int          last_change = 0;
    logic [8:0]  prev_val;
    logic [47:0] pub_w = '0;
    logic [47:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] frame_word(input int k);
        return {dat[k][0][15:4], dat[k][1][15:4], dat[k][2][15:4], dat[k][3][15:4]};
    endfunction

    function automatic logic [47:0] gw(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic rand_frame(input int k);
        for (int s = 0; s < 4; s++) dat[k][s] = 16'($urandom());
    endtask

    // One clock: observe at the falling edge, then drive drdy/do for the
    // rest of the cycle as the XADC would.
    task automatic tick();
        logic [8:0]  v;
        logic [47:0] o;
        int          s;
        @(negedge clk);
        cyc++;
        v = {joy_s, drp_daddr};
        o = {left_x, left_y, right_x, right_y};
        if (v !== prev_val) last_change = cyc;
        prev_val = v;
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc_q.push_back(cyc);
            got_q.push_back(o);
            pub_w = o;
        end else if (o !== pub_w) begin
            hold_viol++;
        end
        if (timeout_err === 1'b1 && to_rise_cyc < 0) to_rise_cyc = cyc;
        if (in_req && v !== req_val) stab_viol++;

        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                drp_drdy   = 1'b1;
                drp_do     = dat[resp_frame][req_slot];
                in_req     = 0;
                since_drdy = 0;
                exp_slot   = (req_slot + 1) % 4;
                if (req_slot == 3 && resp_frame < 7) resp_frame++;
            end
        end else begin
            since_drdy++;
            if (stray_en && since_drdy == 2) begin
                drp_drdy = 1'b1;
                drp_do   = 16'hFFF0;
                stray_cnt++;
            end
        end
        if (drp_den === 1'b1) begin
            den_cnt++;
            s = (joy_s ? 2 : 0) + (drp_daddr == 8'h1B ? 1 : 0);
            if (first_den_slot < 0) first_den_slot = s;
            if (s != exp_slot) seq_viol++;
            if (!in_req && (cyc - last_change) < S) stab_viol++;
            if (s == 1) s1_den_cyc.push_back(cyc);
            in_req   = 1;
            req_slot = s;
            req_val  = v;
            if (withhold_s1 && s == 1) withhold_s1 = 0;
            else cd = lat;
        end
    endtask

    task automatic clear_model();
        cd = 0; in_req = 0; exp_slot = 0; resp_frame = 0;
        withhold_s1 = 0; stray_en = 0; pub_w = '0;
    endtask

    task automatic wait_fv(input string tag, input int target, input int budget);
        int k = 0;
        while (fv_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, fv_cnt, target);
    endtask

    // Pulses enable for one cycle, waits for the frame and checks its
    // timing against 4*(S+1+D)+extra and its data against dat[0].
    task automatic one_frame(input string tag, input int l, input int extra);
        int e;
        lat = l; resp_frame = 0; den_cnt = 0; fv_cnt = 0;
        got_q.delete(); fv_cyc_q.delete();
        enable = 1'b1;
        e = cyc;
        tick();
        enable = 1'b0;
        wait_fv({tag, "_fv"}, 1, 400);
        chk({tag, "_cycle"}, qi(fv_cyc_q, 0), e + 1 + 4 * (S + 1 + l) + extra);
        chk({tag, "_data"}, gw(0), frame_word(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, k, snap;
        rst = 1'b1; enable = 1'b0; drp_drdy = 1'b0; drp_do = 16'h0;

        // Reset and idle
        clear_model();
        repeat (3) tick();
        rst = 1'b0;
        den_cnt = 0;
        repeat (20) tick();
        chk("idle_outputs", {left_x, left_y, right_x, right_y}, 48'h0);
        chk("idle_daddr", drp_daddr, 8'h13);
        chk("idle_joy_s", joy_s, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_den_count", den_cnt, 0);
        chk("idle_fv_terr", {frame_valid, timeout_err}, 2'b00);

        // Single frame with the reference sample values
        dat[0][0] = 16'h1230; dat[0][1] = 16'h4560;
        dat[0][2] = 16'h7890; dat[0][3] = 16'hABC0;
        one_frame("single", 1, 0);
        chk("single_den_count", den_cnt, 4);
        repeat (10) tick();
        chk("single_fv_once", fv_cnt, 1);
        chk("single_busy_after", busy, 1'b0);
        chk("single_outputs", {left_x, left_y, right_x, right_y}, 48'h123456789ABC);

        // Continuous frames with enable held high
        for (int f = 0; f < 3; f++) rand_frame(f);
        lat = $urandom_range(1, 3);
        resp_frame = 0; den_cnt = 0; fv_cnt = 0;
        got_q.delete(); fv_cyc_q.delete();
        enable = 1'b1;
        e = cyc;
        k = 0;
        while (fv_cnt < 3 && k < 600) begin
            tick();
            k++;
            if (fv_cnt == 3) enable = 1'b0;
        end
        enable = 1'b0;
        chk("cont_fv_count", fv_cnt, 3);
        chk("cont_first_cycle", qi(fv_cyc_q, 0), e + 1 + 4 * (S + 1 + lat));
        chk("cont_period_1", qi(fv_cyc_q, 1) - qi(fv_cyc_q, 0), 4 * (S + 1 + lat) + 1);
        chk("cont_period_2", qi(fv_cyc_q, 2) - qi(fv_cyc_q, 1), 4 * (S + 1 + lat) + 1);
        for (int f = 0; f < 3; f++) chk($sformatf("cont_data_%0d", f), gw(f), frame_word(f));
        chk("cont_den_count", den_cnt, 12);
        repeat (5) tick();
        chk("cont_busy_after", busy, 1'b0);

        // drdy timeout on the first slot-1 request
        chk("to_err_before", timeout_err, 1'b0);
        rand_frame(0);
        withhold_s1 = 1; s1_den_cyc.delete(); to_rise_cyc = -1;
        one_frame("timeout", 1, T + 1);
        chk("to_s1_requests", s1_den_cyc.size(), 2);
        chk("to_retry_gap", qi(s1_den_cyc, 1) - qi(s1_den_cyc, 0), T + 1);
        chk("to_err_rise", to_rise_cyc, qi(s1_den_cyc, 1));
        chk("to_den_count", den_cnt, 5);
        repeat (10) tick();
        chk("to_err_sticky", timeout_err, 1'b1);

        // Stray drdy while settling / idle
        rand_frame(0);
        stray_en = 1; stray_cnt = 0;
        one_frame("stray", 2, 0);
        repeat (10) tick();
        stray_en = 0;
        chk("stray_injected", stray_cnt, 4);
        chk("stray_outputs", {left_x, left_y, right_x, right_y}, frame_word(0));
        chk("stray_fv_once", fv_cnt, 1);

        // Reset during the slot-2 read
        rand_frame(0);
        lat = 3; resp_frame = 0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        k = 0;
        while (!(in_req && req_slot == 2) && k < 300) begin
            tick();
            k++;
        end
        chk("rst_reach_slot2", in_req ? req_slot : -1, 2);
        tick();
        rst = 1'b1;
        clear_model();
        snap = fv_cnt;
        tick();
        rst = 1'b0;
        chk("rst_den", drp_den, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outputs", {left_x, left_y, right_x, right_y}, 48'h0);
        chk("rst_fv_terr", {frame_valid, timeout_err}, 2'b00);
        repeat (30) tick();
        chk("rst_no_fv", fv_cnt, snap);
        rand_frame(0);
        first_den_slot = -1;
        one_frame("rst_reenable", 2, 0);
        chk("rst_first_slot", first_den_slot, 0);

        chk("sequence_violations", seq_viol, 0);
        chk("stability_violations", stab_viol, 0);
        chk("hold_violations", hold_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
